vrf_mp_sb: RTL and testbench

//  Multi-ported vector register file with registered reads, write-to-read bypass and a per-register busy scoreboard.

---
 rtl/vrf_mp_sb.sv | 172 +++++++++++++++++
 tb/tb_vrf_mp_sb.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/vrf_mp_sb.sv
`default_nettype none
// ============================================================================
// Module   : vrf_mp_sb
// Brief    : Multi-ported vector register file with registered reads,
//            write-to-read bypass and a per-register busy scoreboard.
// Revision : 1.0
// ============================================================================
module vrf_mp_sb #(
  parameter int els_p    = 32,
  parameter int vlen_p   = 8,
  parameter int vdw_p    = 32,
  parameter int lanes_p  = 4,
  parameter int rports_p = 2,
  localparam int c_rag = (els_p  > 1) ? $clog2(els_p)  : 1,
  localparam int c_eag = (vlen_p > 1) ? $clog2(vlen_p) : 1,
  localparam int c_np  = rports_p * lanes_p
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [c_np-1:0]            r_v_i,
  input  logic [c_np*c_rag-1:0]      r_reg_addr_i,
  input  logic [lanes_p*c_eag-1:0]   r_addr_i,
  output logic [c_np-1:0]            r_v_o,
  output logic [c_np*vdw_p-1:0]      r_data_o,
  output logic [c_np-1:0]            r_hazard_o,
  input  logic [lanes_p-1:0]         w_en_i,
  input  logic [lanes_p*c_rag-1:0]   w_reg_addr_i,
  input  logic [lanes_p*c_eag-1:0]   w_addr_i,
  input  logic [lanes_p*vdw_p-1:0]   w_data_i,
  input  logic                       reserve_v_i,
  input  logic [c_rag-1:0]           reserve_reg_i,
  input  logic                       release_v_i,
  input  logic [c_rag-1:0]           release_reg_i,
  output logic [els_p-1:0]           busy_o,
  output logic                       conflict_o
);

  // One extra bit so the counts themselves are representable for range checks.
  localparam logic [c_rag:0] c_els  = (c_rag+1)'(els_p);
  localparam logic [c_eag:0] c_vlen = (c_eag+1)'(vlen_p);

  logic [c_rag-1:0]   w_wreg [lanes_p];
  logic [c_eag-1:0]   w_wel  [lanes_p];
  logic [vdw_p-1:0]   w_wdat [lanes_p];
  logic [lanes_p-1:0] w_wok;

  logic [vdw_p-1:0]   w_mem [els_p][vlen_p];

  logic [c_np*vdw_p-1:0] w_rdata;
  logic [c_np-1:0]       w_rhaz;

  logic [c_np-1:0]       r_v;
  logic [c_np*vdw_p-1:0] r_data;
  logic [c_np-1:0]       r_haz;
  logic [els_p-1:0]      r_busy;
  logic [els_p-1:0]      w_busy_nxt;
  logic                  r_conflict;
  logic                  w_res_ok;
  logic                  w_rls_ok;
  logic                  w_conflict;

  for (genvar l = 0; l < lanes_p; l++) begin : g_wlane
    assign w_wreg[l] = w_reg_addr_i[l*c_rag +: c_rag];
    assign w_wel[l]  = w_addr_i[l*c_eag +: c_eag];
    assign w_wdat[l] = w_data_i[l*vdw_p +: vdw_p];
    assign w_wok[l]  = w_en_i[l] & ({1'b0, w_wreg[l]} < c_els)
                                 & ({1'b0, w_wel[l]}  < c_vlen);
  end

  // Storage: later lanes in the scan override earlier ones, so the highest lane wins.
  for (genvar r = 0; r < els_p; r++) begin : g_reg
    for (genvar e = 0; e < vlen_p; e++) begin : g_el
      logic [vdw_p-1:0] r_q;
      logic [vdw_p-1:0] w_d;

      always_comb begin
        w_d = r_q;
        for (int l = 0; l < lanes_p; l++) begin
          if (w_wok[l] && (w_wreg[l] == c_rag'(r)) && (w_wel[l] == c_eag'(e))) begin
            w_d = w_wdat[l];
          end
        end
      end

      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
          r_q <= '0;
        end else begin
          r_q <= w_d;
        end
      end

      assign w_mem[r][e] = r_q;
    end
  end

  for (genvar i = 0; i < c_np; i++) begin : g_port
    localparam int c_lane = i % lanes_p;
    logic [c_rag-1:0] w_rreg;
    logic [c_eag-1:0] w_rel;
    logic             w_rok;
    logic [vdw_p-1:0] w_rd;

    assign w_rreg = r_reg_addr_i[i*c_rag +: c_rag];
    assign w_rel  = r_addr_i[c_lane*c_eag +: c_eag];
    assign w_rok  = ({1'b0, w_rreg} < c_els) & ({1'b0, w_rel} < c_vlen);

    // Same-cycle writes are forwarded so the reader sees the value being committed.
    always_comb begin
      w_rd = w_rok ? w_mem[w_rreg][w_rel] : '0;
      for (int l = 0; l < lanes_p; l++) begin
        if (w_rok && w_wok[l] && (w_wreg[l] == w_rreg) && (w_wel[l] == w_rel)) begin
          w_rd = w_wdat[l];
        end
      end
    end

    assign w_rdata[i*vdw_p +: vdw_p] = w_rd;
    assign w_rhaz[i]                 = w_rok & r_busy[w_rreg];
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_v    <= '0;
      r_data <= '0;
      r_haz  <= '0;
    end else begin
      r_v <= r_v_i;
      for (int i = 0; i < c_np; i++) begin
        if (r_v_i[i]) begin
          r_data[i*vdw_p +: vdw_p] <= w_rdata[i*vdw_p +: vdw_p];
          r_haz[i]                 <= w_rhaz[i];
        end
      end
    end
  end

  assign w_res_ok = reserve_v_i & ({1'b0, reserve_reg_i} < c_els);
  assign w_rls_ok = release_v_i & ({1'b0, release_reg_i} < c_els);

  // Reserve is applied after release so a same-cycle pair leaves the register busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_rls_ok) begin
      w_busy_nxt[release_reg_i] = 1'b0;
    end
    if (w_res_ok) begin
      w_busy_nxt[reserve_reg_i] = 1'b1;
    end
  end

  assign w_conflict = w_res_ok & r_busy[reserve_reg_i]
                    & ~(w_rls_ok & (release_reg_i == reserve_reg_i));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_busy     <= '0;
      r_conflict <= 1'b0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_conflict <= r_conflict | w_conflict;
    end
  end

  assign r_v_o      = r_v;
  assign r_data_o   = r_data;
  assign r_hazard_o = r_haz;
  assign busy_o     = r_busy;
  assign conflict_o = r_conflict;

endmodule
`default_nettype wire

// File: tb/tb_vrf_mp_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_vrf_mp_sb
// Brief    : Directed and randomised-address bench for vrf_mp_sb.
// Revision : 1.0
// ============================================================================
module tb_vrf_mp_sb;
  localparam int ELS = 32, VLEN = 8, VDW = 32, LANES = 4, RP = 2;
  localparam int NP = RP * LANES, RAG = 5, EAG = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NP-1:0]        r_v;
  logic [NP*RAG-1:0]    r_reg;
  logic [LANES*EAG-1:0] r_el;
  logic [NP-1:0]        r_v_o;
  logic [NP*VDW-1:0]    r_data_o;
  logic [NP-1:0]        r_hazard_o;
  logic [LANES-1:0]     w_en;
  logic [LANES*RAG-1:0] w_reg;
  logic [LANES*EAG-1:0] w_el;
  logic [LANES*VDW-1:0] w_data;
  logic                 reserve_v, release_v;
  logic [RAG-1:0]       reserve_reg, release_reg;
  logic [ELS-1:0]       busy_o;
  logic                 conflict_o;

  vrf_mp_sb dut (
    .clk_i(clk), .reset_i(rst),
    .r_v_i(r_v), .r_reg_addr_i(r_reg), .r_addr_i(r_el),
    .r_v_o(r_v_o), .r_data_o(r_data_o), .r_hazard_o(r_hazard_o),
    .w_en_i(w_en), .w_reg_addr_i(w_reg), .w_addr_i(w_el), .w_data_i(w_data),
    .reserve_v_i(reserve_v), .reserve_reg_i(reserve_reg),
    .release_v_i(release_v), .release_reg_i(release_reg),
    .busy_o(busy_o), .conflict_o(conflict_o)
  );

  int vectors = 0;
  int fails   = 0;
  logic run = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: writes land first, then reads see the updated array,
  // which is what a same-cycle bypass must look like from outside.
  logic [VDW-1:0] m_mem [ELS][VLEN];
  logic [ELS-1:0] m_busy, m_pre;
  logic           m_conf;
  logic [NP-1:0]  e_v, e_haz;
  logic [VDW-1:0] e_data [NP];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < ELS; r++)
        for (int e = 0; e < VLEN; e++) m_mem[r][e] = '0;
      m_busy = '0; m_conf = 1'b0; e_v = '0; e_haz = '0;
      for (int i = 0; i < NP; i++) e_data[i] = '0;
    end else begin
      m_pre = m_busy;
      for (int l = 0; l < LANES; l++)
        if (w_en[l]) m_mem[w_reg[l*RAG +: RAG]][w_el[l*EAG +: EAG]] = w_data[l*VDW +: VDW];
      e_v = r_v;
      for (int i = 0; i < NP; i++) begin
        if (r_v[i]) begin
          e_data[i] = m_mem[r_reg[i*RAG +: RAG]][r_el[(i % LANES)*EAG +: EAG]];
          e_haz[i]  = m_pre[r_reg[i*RAG +: RAG]];
        end
      end
      if (reserve_v && m_pre[reserve_reg] && !(release_v && release_reg == reserve_reg))
        m_conf = 1'b1;
      if (release_v) m_busy[release_reg] = 1'b0;
      if (reserve_v) m_busy[reserve_reg] = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("r_v_o", 64'(r_v_o), 64'(e_v));
      chk("r_hazard_o", 64'(r_hazard_o), 64'(e_haz));
      chk("busy_o", 64'(busy_o), 64'(m_busy));
      chk("conflict_o", 64'(conflict_o), 64'(m_conf));
      for (int i = 0; i < NP; i++)
        chk($sformatf("r_data_o[%0d]", i), 64'(r_data_o[i*VDW +: VDW]), 64'(e_data[i]));
    end
  end

  task automatic idle();
    r_v = '0; w_en = '0; reserve_v = 1'b0; release_v = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    idle();
  endtask

  task automatic rd(input int p, input int l, input int rg, input int el);
    r_v[p*LANES + l] = 1'b1;
    r_reg[(p*LANES + l)*RAG +: RAG] = RAG'(rg);
    r_el[l*EAG +: EAG] = EAG'(el);
  endtask

  task automatic wr(input int l, input int rg, input int el, input logic [VDW-1:0] d);
    w_en[l] = 1'b1;
    w_reg[l*RAG +: RAG] = RAG'(rg);
    w_el[l*EAG +: EAG] = EAG'(el);
    w_data[l*VDW +: VDW] = d;
  endtask

  int base, stride;

  initial begin
    idle();
    r_reg = '0; r_el = '0; w_reg = '0; w_el = '0; w_data = '0;
    reserve_reg = '0; release_reg = '0;
    repeat (2) @(negedge clk);
    chk("reset r_v_o", 64'(r_v_o), 64'd0);
    chk("reset busy_o", 64'(busy_o), 64'd0);
    chk("reset conflict_o", 64'(conflict_o), 64'd0);
    chk("reset r_data_o", 64'(|r_data_o), 64'd0);
    rst = 1'b0;
    run = 1'b1;

    // Write then read one cycle later from storage
    wr(0, 5, 2, 32'hDEADBEEF);
    tick(); rd(1, 0, 5, 2);
    tick();
    chk("rd p1l0 data", 64'(r_data_o[4*VDW +: VDW]), 64'hDEADBEEF);
    chk("rd p1l0 valid", 64'(r_v_o[4]), 64'd1);

    // Bypass and lane priority
    wr(0, 3, 1, 32'h11); rd(0, 0, 3, 1);
    tick();
    chk("bypass l0", 64'(r_data_o[0 +: VDW]), 64'h11);
    wr(1, 3, 1, 32'h22); wr(3, 3, 1, 32'h33); rd(0, 1, 3, 1);
    tick();
    chk("bypass hi lane", 64'(r_data_o[1*VDW +: VDW]), 64'h33);
    rd(1, 2, 3, 1);
    tick();
    chk("stored hi lane", 64'(r_data_o[6*VDW +: VDW]), 64'h33);

    // Scoreboard hazard and reserve+release
    reserve_v = 1'b1; reserve_reg = 5'd7;
    tick();
    chk("busy7 set", 64'(busy_o[7]), 64'd1);
    rd(0, 0, 7, 0);
    tick();
    chk("hazard reg7", 64'(r_hazard_o[0]), 64'd1);
    reserve_v = 1'b1; reserve_reg = 5'd7; release_v = 1'b1; release_reg = 5'd7;
    rd(0, 3, 7, 4);
    tick();
    chk("busy7 kept", 64'(busy_o[7]), 64'd1);
    chk("no conflict", 64'(conflict_o), 64'd0);
    chk("hazard pre-release", 64'(r_hazard_o[3]), 64'd1);
    release_v = 1'b1; release_reg = 5'd7;
    tick();
    chk("busy7 cleared", 64'(busy_o[7]), 64'd0);
    rd(0, 0, 7, 0);
    tick();
    chk("hazard cleared", 64'(r_hazard_o[0]), 64'd0);

    // Double reserve -> sticky conflict
    reserve_v = 1'b1; reserve_reg = 5'd9;
    tick();
    reserve_v = 1'b1; reserve_reg = 5'd9;
    tick();
    chk("conflict set", 64'(conflict_o), 64'd1);
    repeat (3) tick();
    chk("conflict sticky", 64'(conflict_o), 64'd1);

    // Reset between edges with a read in flight
    rd(0, 0, 5, 2); reserve_v = 1'b1; reserve_reg = 5'd12;
    tick();
    chk("pre-reset data", 64'(r_data_o[0 +: VDW]), 64'hDEADBEEF);
    rd(0, 0, 5, 2);
    #2 rst = 1'b1;
    #1;
    chk("async r_v_o", 64'(r_v_o), 64'd0);
    chk("async r_data_o", 64'(|r_data_o), 64'd0);
    chk("async busy_o", 64'(busy_o), 64'd0);
    chk("async conflict_o", 64'(conflict_o), 64'd0);
    chk("async hazard", 64'(r_hazard_o), 64'd0);
    #1 rst = 1'b0;
    tick();

    // Distinct registers on every port, random elements and writes
    for (int c = 0; c < 1000; c++) begin
      base   = int'($urandom_range(0, 31));
      stride = 2 * int'($urandom_range(0, 15)) + 1;
      for (int i = 0; i < NP; i++) begin
        r_v[i] = ($urandom_range(0, 7) != 0);
        r_reg[i*RAG +: RAG] = RAG'((base + i*stride) % ELS);
      end
      for (int l = 0; l < LANES; l++) r_el[l*EAG +: EAG] = EAG'($urandom_range(0, 7));
      for (int l = 0; l < LANES; l++) begin
        if ($urandom_range(0, 1) == 1)
          wr(l, (base + int'($urandom_range(0, 7))*stride) % ELS,
             ($urandom_range(0, 1) == 1) ? int'(r_el[l*EAG +: EAG]) : int'($urandom_range(0, 7)),
             $urandom);
      end
      reserve_v   = ($urandom_range(0, 3) == 0);
      reserve_reg = RAG'($urandom_range(0, 31));
      release_v   = ($urandom_range(0, 2) == 0);
      release_reg = RAG'($urandom_range(0, 31));
      tick();
    end

    tick(); tick();
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
`default_nettype wire
